// File: rtl/wiper_pkg.sv
// Shared types and encodings for the parametrised wiper controller.
package wiper_pkg;

    typedef enum logic [1:0] {
        W_OFF  = 2'd0,
        W_SLOW = 2'd1,
        W_FAST = 2'd2
    } speed_t;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_SLOW    = 2'd1,
        ST_FAST    = 2'd2,
        ST_PARKING = 2'd3
    } wstate_t;

    localparam logic [1:0] MODE_AUTO = 2'b00;
    localparam logic [1:0] MODE_OFF  = 2'b01;
    localparam logic [1:0] MODE_SLOW = 2'b10;
    localparam logic [1:0] MODE_FAST = 2'b11;

endpackage

// File: rtl/wiper_ctrl_param_persist.sv
// Level-to-target hysteresis: a level must persist for PERSIST_UP / PERSIST_DOWN
// ticks before the target follows it; forced modes set the target directly.
module wiper_persist
    import wiper_pkg::*;
#(
    parameter int PERSIST_UP   = 3,
    parameter int PERSIST_DOWN = 4
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       tick,
    input  logic [1:0] mode,
    input  speed_t     level,
    output speed_t     target
);

    localparam int PMAX = (PERSIST_UP > PERSIST_DOWN) ? PERSIST_UP : PERSIST_DOWN;
    localparam int CNTW = (PMAX > 1) ? $clog2(PMAX + 1) : 1;
    localparam logic [CNTW-1:0] UP_LAST = CNTW'(PERSIST_UP - 1);
    localparam logic [CNTW-1:0] DN_LAST = CNTW'(PERSIST_DOWN - 1);

    logic [CNTW-1:0] up_cnt;
    logic [CNTW-1:0] down_cnt;

    always_ff @(posedge clk_2) begin
        if (!reset) begin
            target   <= W_OFF;
            up_cnt   <= '0;
            down_cnt <= '0;
        end else if (tick) begin
            unique case (mode)
                MODE_OFF: begin
                    target   <= W_OFF;
                    up_cnt   <= '0;
                    down_cnt <= '0;
                end
                MODE_SLOW: begin
                    target   <= W_SLOW;
                    up_cnt   <= '0;
                    down_cnt <= '0;
                end
                MODE_FAST: begin
                    target   <= W_FAST;
                    up_cnt   <= '0;
                    down_cnt <= '0;
                end
                default: begin
                    if (level > target) begin
                        down_cnt <= '0;
                        if (up_cnt == UP_LAST) begin
                            target <= level;
                            up_cnt <= '0;
                        end else begin
                            up_cnt <= up_cnt + 1'b1;
                        end
                    end else if (level < target) begin
                        up_cnt <= '0;
                        if (down_cnt == DN_LAST) begin
                            target   <= level;
                            down_cnt <= '0;
                        end else begin
                            down_cnt <= down_cnt + 1'b1;
                        end
                    end else begin
                        up_cnt   <= '0;
                        down_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/wiper_ctrl_param.sv
// Rain-sensing wiper controller: popcount, tick prescaler, hysteresis target,
// speed FSM and a modelled arm sweep that always parks at position 0.
module wiper_ctrl_param
    import wiper_pkg::*;
#(
    parameter int N_SENSORS    = 7,
    parameter int TICK_DIV     = 2,
    parameter int SLOW_TH      = 3,
    parameter int FAST_TH      = 5,
    parameter int PERSIST_UP   = 3,
    parameter int PERSIST_DOWN = 4,
    parameter int SWEEP_LEN    = 8
) (
    input  logic                           clk_2,
    input  logic                           reset,
    input  logic [N_SENSORS-1:0]           drops,
    input  logic [1:0]                     mode,
    output logic [1:0]                     speed,
    output logic                           parking,
    output logic                           parked,
    output logic [$clog2(SWEEP_LEN)-1:0]   sweep_pos,
    output logic                           sweep_done,
    output logic [$clog2(N_SENSORS+1)-1:0] drop_count,
    output logic                           tick
);

    // state | meaning
    // OFF     | motor stopped, arm held (parked when pos==0)
    // SLOW    | sweeping one position per tick
    // FAST    | sweeping two positions per tick
    // PARKING | finishing the sweep at park_spd until pos wraps to 0

    localparam int CW  = $clog2(N_SENSORS + 1);
    localparam int PW  = $clog2(SWEEP_LEN);
    localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  SLOW_TH_C = CW'(SLOW_TH);
    localparam logic [CW-1:0]  FAST_TH_C = CW'(FAST_TH);
    localparam logic [PSW-1:0] PRE_LAST  = PSW'(TICK_DIV - 1);
    localparam logic [PW:0]    SWEEP_END = (PW + 1)'(SWEEP_LEN);

    logic [PSW-1:0] pre_cnt;
    logic [CW-1:0]  pop;
    speed_t         level;
    speed_t         target;
    speed_t         park_spd;
    speed_t         park_spd_nxt;
    speed_t         speed_int;
    wstate_t        state;
    wstate_t        state_nxt;
    logic [PW:0]    pos_sum;
    logic [PW-1:0]  pos_nxt;

    // Prescaler
    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk_2) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            pop = pop + CW'(drops[i]);
        end
    end

    always_ff @(posedge clk_2) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (tick) begin
            drop_count <= pop;
        end
    end

    always_comb begin
        if (drop_count >= FAST_TH_C) begin
            level = W_FAST;
        end else if (drop_count >= SLOW_TH_C) begin
            level = W_SLOW;
        end else begin
            level = W_OFF;
        end
    end

    wiper_persist #(
        .PERSIST_UP   (PERSIST_UP),
        .PERSIST_DOWN (PERSIST_DOWN)
    ) u_persist (
        .clk_2  (clk_2),
        .reset  (reset),
        .tick   (tick),
        .mode   (mode),
        .level  (level),
        .target (target)
    );

    always_comb begin
        unique case (state)
            ST_SLOW:    speed_int = W_SLOW;
            ST_FAST:    speed_int = W_FAST;
            ST_PARKING: speed_int = park_spd;
            default:    speed_int = W_OFF;
        endcase
    end

    // Overshoot past the end snaps to 0 so the park position is never skipped.
    assign pos_sum = {1'b0, sweep_pos} + (PW + 1)'(speed_int);
    assign pos_nxt = (pos_sum >= SWEEP_END) ? '0 : pos_sum[PW-1:0];

    always_comb begin
        state_nxt    = state;
        park_spd_nxt = park_spd;
        if (tick) begin
            unique case (state)
                ST_OFF: begin
                    if (target == W_SLOW) begin
                        state_nxt = ST_SLOW;
                    end else if (target == W_FAST) begin
                        state_nxt = ST_FAST;
                    end
                end
                ST_SLOW: begin
                    if (target == W_FAST) begin
                        state_nxt = ST_FAST;
                    end else if (target == W_OFF) begin
                        state_nxt    = ST_PARKING;
                        park_spd_nxt = W_SLOW;
                    end
                end
                ST_FAST: begin
                    if (target == W_SLOW) begin
                        state_nxt = ST_SLOW;
                    end else if (target == W_OFF) begin
                        state_nxt    = ST_PARKING;
                        park_spd_nxt = W_FAST;
                    end
                end
                default: begin
                    if (target == W_SLOW) begin
                        state_nxt = ST_SLOW;
                    end else if (target == W_FAST) begin
                        state_nxt = ST_FAST;
                    end else if (pos_nxt == '0) begin
                        state_nxt = ST_OFF;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_2) begin
        if (!reset) begin
            state      <= ST_OFF;
            park_spd   <= W_OFF;
            sweep_pos  <= '0;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            park_spd   <= park_spd_nxt;
            sweep_done <= tick && (sweep_pos != '0) && (pos_nxt == '0);
            if (tick) begin
                sweep_pos <= pos_nxt;
            end
        end
    end

    assign speed   = speed_int;
    assign parking = (state == ST_PARKING);
    assign parked  = (state == ST_OFF) && (sweep_pos == '0);

endmodule
